systolic_matmul_top: RTL and testbench

- Output-stationary systolic matrix multiplier: Z = A x B, A is array_height_p x K, B is K x array_width_p, K arbitrary.
- Operands arrive serially on one valid/ready byte stream, one "wave" (one k-slice) at a time.
- Results leave serially, row-major, on a valid/yumi stream after flush_i.
- Top-level compute block; sits between a serial host interface and the array of MAC PEs.

---
 rtl/systolic_pkg.sv | 30 +++
 rtl/systolic_pe.sv | 53 +++++
 rtl/systolic_matmul_top.sv | 167 ++++++++++++++++
 tb/tb_systolic_matmul_top.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// ---------------------------------------------------------------------------
// systolic_pkg
// Shared types and sizing helpers for the output-stationary systolic
// matrix multiplier.
//   state_e    : controller states (LOAD, PUSH, DRAIN)
//   wave_len   : words per k-slice wave (one per column plus one per row)
//   push_len   : cycles needed for a wave to sweep the array diagonally
//   elem_count : number of result elements streamed out on a drain
// ---------------------------------------------------------------------------
package systolic_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        PUSH  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic int unsigned wave_len(input int unsigned w, input int unsigned h);
        return w + h;
    endfunction

    function automatic int unsigned push_len(input int unsigned w, input int unsigned h);
        return w + h - 1;
    endfunction

    function automatic int unsigned elem_count(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// ---------------------------------------------------------------------------
// systolic_pe
// One multiply-accumulate cell. The a operand passes right and the b operand
// passes down through one register stage each, with their valid bits. The
// accumulator adds a*b (mod 2^width_p) when both inputs are valid.
//   clk_i, reset_i : clock, async active-low reset
//   en_i           : clock enable, all registers hold when low
//   clear_i        : zero the accumulator (wins over a MAC the same cycle)
//   a_i/a_v_i      : operand from the left and its valid bit
//   b_i/b_v_i      : operand from above and its valid bit
//   a_o/a_v_o      : registered a towards the right neighbour
//   b_o/b_v_o      : registered b towards the lower neighbour
//   acc_o          : accumulator value
// ---------------------------------------------------------------------------
module systolic_pe #(
    parameter int unsigned width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic               clear_i,
    input  logic [width_p-1:0] a_i,
    input  logic               a_v_i,
    input  logic [width_p-1:0] b_i,
    input  logic               b_v_i,
    output logic [width_p-1:0] a_o,
    output logic               a_v_o,
    output logic [width_p-1:0] b_o,
    output logic               b_v_o,
    output logic [width_p-1:0] acc_o
);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            a_o   <= '0;
            a_v_o <= 1'b0;
            b_o   <= '0;
            b_v_o <= 1'b0;
            acc_o <= '0;
        end else if (en_i) begin
            a_o   <= a_i;
            a_v_o <= a_v_i;
            b_o   <= b_i;
            b_v_o <= b_v_i;
            if (clear_i) begin
                acc_o <= '0;
            end else if (a_v_i && b_v_i) begin
                acc_o <= acc_o + a_i * b_i;
            end
        end
    end

endmodule

// File: rtl/systolic_matmul_top.sv
// ---------------------------------------------------------------------------
// systolic_matmul_top
// Output-stationary systolic multiplier Z = A x B. Operands arrive one wave
// (k-slice) at a time on a valid/ready byte stream: first B[k][0..W-1], then
// A[0..H-1][k]. Each wave is pushed diagonally through the PE array; after a
// flush the accumulated Z streams out row-major on a valid/yumi interface and
// the accumulators are cleared.
//   clk_i, reset_i : clock, async active-low reset
//   en_i           : global clock enable
//   flush_i        : request to stream out Z
//   ready_o        : operand word accepted on valid_i & ready_o
//   valid_i/data_i : operand stream
//   valid_o/data_o : result stream (data_o is 0 when valid_o is 0)
//   yumi_i         : consumer takes data_o this cycle
// ---------------------------------------------------------------------------
module systolic_matmul_top
    import systolic_pkg::*;
#(
    parameter int unsigned width_p        = 8,
    parameter int unsigned array_width_p  = 2,
    parameter int unsigned array_height_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic               flush_i,
    output logic               ready_o,
    input  logic               valid_i,
    input  logic [width_p-1:0] data_i,
    output logic               valid_o,
    input  logic               yumi_i,
    output logic [width_p-1:0] data_o
);

    localparam int unsigned WAVE_LEN = wave_len(array_width_p, array_height_p);
    localparam int unsigned PUSH_LEN = push_len(array_width_p, array_height_p);
    localparam int unsigned ELEMS    = elem_count(array_width_p, array_height_p);
    localparam int unsigned CNT_W    = (WAVE_LEN > 1) ? $clog2(WAVE_LEN) : 1;
    localparam int unsigned IDX_W    = (ELEMS > 1) ? $clog2(ELEMS) : 1;

    state_e             state_q, state_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;     // word count in LOAD, cycle count in PUSH
    logic [IDX_W-1:0]   idx_q, idx_n;
    logic               pend_q, pend_n;
    logic               accept;
    logic               clear;
    logic [width_p-1:0] stage_q [WAVE_LEN];

    // Operand/valid nets between PEs: a flows along j, b flows along i.
    logic [width_p-1:0] a_d [array_height_p][array_width_p+1];
    logic               a_v [array_height_p][array_width_p+1];
    logic [width_p-1:0] b_d [array_height_p+1][array_width_p];
    logic               b_v [array_height_p+1][array_width_p];
    logic [width_p-1:0] acc [ELEMS];

    // Outputs are gated by reset so they read 0 immediately on assertion.
    assign ready_o = reset_i && (state_q == LOAD);
    assign valid_o = reset_i && (state_q == DRAIN);
    assign data_o  = valid_o ? acc[idx_q] : '0;

    // flush_i voids a coincident word even though ready_o is high.
    assign accept = en_i && valid_i && ready_o && !flush_i;
    assign clear  = en_i && valid_o && yumi_i && (idx_q == IDX_W'(ELEMS - 1));

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        idx_n   = idx_q;
        pend_n  = pend_q;
        case (state_q)
            LOAD: begin
                if (flush_i) begin
                    state_n = DRAIN;
                    cnt_n   = '0;
                end else if (accept) begin
                    if (cnt_q == CNT_W'(WAVE_LEN - 1)) begin
                        state_n = PUSH;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end
            end
            PUSH: begin
                pend_n = pend_q || flush_i;
                if (cnt_q == CNT_W'(PUSH_LEN - 1)) begin
                    cnt_n   = '0;
                    pend_n  = 1'b0;
                    state_n = (pend_q || flush_i) ? DRAIN : LOAD;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (yumi_i) begin
                    if (idx_q == IDX_W'(ELEMS - 1)) begin
                        idx_n   = '0;
                        state_n = LOAD;
                    end else begin
                        idx_n = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_n = LOAD;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            idx_q   <= '0;
            pend_q  <= 1'b0;
        end else if (en_i) begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            idx_q   <= idx_n;
            pend_q  <= pend_n;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int unsigned k = 0; k < WAVE_LEN; k++) begin
                stage_q[k] <= '0;
            end
        end else if (accept) begin
            stage_q[cnt_q] <= data_i;
        end
    end

    // Skew: instead of explicit delay lines, row i / column j present their
    // staged operand as valid on PUSH cycle i / j. The data is static for the
    // whole PUSH, so this is equivalent to an i- or j-deep delay chain.
    for (genvar gi = 0; gi < array_height_p; gi++) begin : g_row_feed
        assign a_d[gi][0] = stage_q[array_width_p + gi];
        assign a_v[gi][0] = (state_q == PUSH) && (cnt_q == CNT_W'(gi));
    end

    for (genvar gj = 0; gj < array_width_p; gj++) begin : g_col_feed
        assign b_d[0][gj] = stage_q[gj];
        assign b_v[0][gj] = (state_q == PUSH) && (cnt_q == CNT_W'(gj));
    end

    for (genvar gi = 0; gi < array_height_p; gi++) begin : g_row
        for (genvar gj = 0; gj < array_width_p; gj++) begin : g_col
            systolic_pe #(
                .width_p (width_p)
            ) u_pe (
                .clk_i   (clk_i),
                .reset_i (reset_i),
                .en_i    (en_i),
                .clear_i (clear),
                .a_i     (a_d[gi][gj]),
                .a_v_i   (a_v[gi][gj]),
                .b_i     (b_d[gi][gj]),
                .b_v_i   (b_v[gi][gj]),
                .a_o     (a_d[gi][gj+1]),
                .a_v_o   (a_v[gi][gj+1]),
                .b_o     (b_d[gi+1][gj]),
                .b_v_o   (b_v[gi+1][gj]),
                .acc_o   (acc[gi*array_width_p + gj])
            );
        end
    end

endmodule

// File: tb/tb_systolic_matmul_top.sv
module tb_systolic_matmul_top;

    logic       clk_i   = 1'b0;
    logic       reset_i = 1'b0;
    logic       en_i    = 1'b1;
    logic       flush_i = 1'b0;
    logic       valid_i = 1'b0;
    logic [7:0] data_i  = '0;
    logic       yumi_i  = 1'b0;
    logic       ready_o;
    logic       valid_o;
    logic [7:0] data_o;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    logic [7:0]  exp_q [$];
    logic [7:0]  mon_e;

    systolic_matmul_top #(
        .width_p        (8),
        .array_width_p  (2),
        .array_height_p (2)
    ) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (en_i),
        .flush_i (flush_i),
        .ready_o (ready_o),
        .valid_i (valid_i),
        .data_i  (data_i),
        .valid_o (valid_o),
        .yumi_i  (yumi_i),
        .data_o  (data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every completed output handshake is checked against the scoreboard.
    always @(negedge clk_i) begin
        if (reset_i && en_i && valid_o && yumi_i) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL drain_extra: got %0d expected no element", data_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("drain_elem", {24'd0, data_o}, {24'd0, mon_e});
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w);
        bit done;
        done    = 1'b0;
        valid_i = 1'b1;
        data_i  = w;
        for (int c = 0; c < 50 && !done; c++) begin
            done = ready_o && en_i && !flush_i;
            tick();
        end
        valid_i = 1'b0;
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_timeout: got ready_o=0 expected ready_o=1 within 50 cycles");
        end
    endtask

    task automatic send_wave(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] a0, input logic [7:0] a1);
        send_word(b0);
        send_word(b1);
        send_word(a0);
        send_word(a1);
    endtask

    task automatic pulse_flush();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
    endtask

    task automatic expect4(input logic [7:0] z0, input logic [7:0] z1,
                           input logic [7:0] z2, input logic [7:0] z3);
        exp_q.push_back(z0);
        exp_q.push_back(z1);
        exp_q.push_back(z2);
        exp_q.push_back(z3);
    endtask

    task automatic drain_n(input int n);
        int rem;
        rem = n;
        for (int c = 0; c < 200 && rem > 0; c++) begin
            yumi_i = valid_o;
            if (yumi_i && en_i) rem--;
            tick();
        end
        yumi_i = 1'b0;
        if (rem > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d elements short expected 0", rem);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_valid"}, {31'd0, valid_o}, 32'd0);
        check({name, "_data"},  {24'd0, data_o},  32'd0);
        check({name, "_ready"}, {31'd0, ready_o}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1;
        check("rst_ready", {31'd0, ready_o}, 32'd0);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_data",  {24'd0, data_o},  32'd0);
        #11 reset_i = 1'b1;
        tick();
        check_idle("post_reset");

        // Basic 2x2: waves k=1 then k=0, flush from LOAD
        send_wave(8'd3, 8'd4, 8'd2, 8'd4);
        send_wave(8'd1, 8'd2, 8'd1, 8'd3);
        repeat (4) tick();
        pulse_flush();
        expect4(8'd7, 8'd10, 8'd15, 8'd22);
        drain_n(4);
        check_idle("basic_end");

        // Repeat after a drain, stalling yumi mid-drain
        send_wave(8'd3, 8'd4, 8'd2, 8'd4);
        send_wave(8'd1, 8'd2, 8'd1, 8'd3);
        repeat (4) tick();
        pulse_flush();
        expect4(8'd7, 8'd10, 8'd15, 8'd22);
        drain_n(2);
        for (int c = 0; c < 3; c++) begin
            check("hold_data",  {24'd0, data_o},  32'd15);
            check("hold_valid", {31'd0, valid_o}, 32'd1);
            tick();
        end
        drain_n(2);
        check_idle("repeat_end");

        // Empty flush, with a coincident word that must be voided
        valid_i = 1'b1;
        data_i  = 8'd99;
        flush_i = 1'b1;
        check("flush_ready", {31'd0, ready_o}, 32'd1);
        tick();
        valid_i = 1'b0;
        flush_i = 1'b0;
        expect4(8'd0, 8'd0, 8'd0, 8'd0);
        drain_n(4);
        check_idle("empty_end");

        // Overflow wraps mod 256
        send_wave(8'd16, 8'd1, 8'd16, 8'd1);
        repeat (4) tick();
        pulse_flush();
        expect4(8'd0, 8'd16, 8'd16, 8'd1);
        drain_n(4);

        // en_i low in PUSH and DRAIN; flush pulsed during PUSH
        // A=[[2,0],[1,3]] B=[[4,5],[6,7]] -> Z=[[8,10],[22,26]]
        send_wave(8'd4, 8'd5, 8'd2, 8'd1);
        en_i = 1'b0;
        repeat (5) tick();
        check("en_push_ready", {31'd0, ready_o}, 32'd0);
        en_i = 1'b1;
        send_wave(8'd6, 8'd7, 8'd0, 8'd3);
        pulse_flush();
        check("flush_pending_valid", {31'd0, valid_o}, 32'd0);
        expect4(8'd8, 8'd10, 8'd22, 8'd26);
        drain_n(1);
        en_i   = 1'b0;
        yumi_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("en_drain_data", {24'd0, data_o}, 32'd10);
            tick();
        end
        yumi_i = 1'b0;
        en_i   = 1'b1;
        drain_n(3);
        check_idle("en_end");

        // Async reset mid-PUSH
        send_wave(8'd1, 8'd2, 8'd1, 8'd3);
        #2 reset_i = 1'b0;
        #1;
        check("rst_push_ready", {31'd0, ready_o}, 32'd0);
        check("rst_push_valid", {31'd0, valid_o}, 32'd0);
        check("rst_push_data",  {24'd0, data_o},  32'd0);
        @(negedge clk_i) reset_i = 1'b1;
        tick();
        send_wave(8'd1, 8'd2, 8'd1, 8'd3);
        send_wave(8'd3, 8'd4, 8'd2, 8'd4);
        repeat (4) tick();
        pulse_flush();
        expect4(8'd7, 8'd10, 8'd15, 8'd22);
        drain_n(1);

        // Async reset mid-DRAIN: outputs drop at once, accumulators zeroed
        #2 reset_i = 1'b0;
        #1;
        check("rst_drain_valid", {31'd0, valid_o}, 32'd0);
        check("rst_drain_data",  {24'd0, data_o},  32'd0);
        exp_q.delete();
        @(negedge clk_i) reset_i = 1'b1;
        tick();
        pulse_flush();
        expect4(8'd0, 8'd0, 8'd0, 8'd0);
        drain_n(4);
        check_idle("final");

        check("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
